// File: rtl/sha256d_nonce_scheduler.sv
// sha256d_nonce_scheduler
// Drives a fully-pipelined double-SHA256 datapath for one block-header job.
// One nonce is launched per clock. A valid shift register tracks which hash
// slots are real. Returning hashes are tagged with their nonce and tested
// against the job target. Winning nonces queue in a small FWFT FIFO for the host.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   work_*              job offer (midstate, header tail, start nonce, target)
//   work_ready          always accepts outside reset
//   dp_midstate/dp_data registered job words to the datapath
//   dp_nonce/dp_valid   nonce launched this cycle
//   hash_in             final hash, PIPE_LATENCY cycles after launch
//   gold_valid/ready    FWFT FIFO head handshake, gold_nonce = head nonce
//   ovf_count           saturating count of goldens dropped on a full FIFO
//   busy                job running or draining
//   work_done           one-cycle pulse when a job has fully drained
module sha256d_nonce_scheduler #(
  parameter int PIPE_LATENCY = 130,
  parameter int NONCE_STRIDE = 1,
  parameter int FIFO_AW      = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] work_midstate,
  input  logic [95:0]  work_data,
  input  logic [31:0]  work_nonce_start,
  input  logic [31:0]  work_target,
  output logic [255:0] dp_midstate,
  output logic [95:0]  dp_data,
  output logic [31:0]  dp_nonce,
  output logic         dp_valid,
  input  logic [255:0] hash_in,
  output logic         gold_valid,
  input  logic         gold_ready,
  output logic [31:0]  gold_nonce,
  output logic [7:0]   ovf_count,
  output logic         busy,
  output logic         work_done
);

  localparam int CW    = $clog2(PIPE_LATENCY + 1);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [255:0]            dp_midstate_q, dp_midstate_d;
  logic [95:0]             dp_data_q, dp_data_d;
  logic [31:0]             target_q, target_d;
  logic [31:0]             dp_nonce_q, dp_nonce_d;
  logic                    dp_valid_q, dp_valid_d;
  logic [PIPE_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [31:0]             res_nonce_q, res_nonce_d;
  logic [CW-1:0]           drain_cnt_q, drain_cnt_d;
  logic                    work_done_q, work_done_d;
  logic                    hit_q, hit_d;
  logic [31:0]             hit_nonce_q, hit_nonce_d;
  logic [FIFO_AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]        cnt_q, cnt_d;
  logic [7:0]              ovf_q, ovf_d;
  logic [31:0]             mem_q [DEPTH];

  logic        accept, v_out, full, do_push, do_pop;
  logic [32:0] next_sum;

  assign accept = work_valid;
  assign v_out  = vld_pipe_q[PIPE_LATENCY-1];
  assign full   = (cnt_q == (FIFO_AW+1)'(DEPTH));
  assign do_pop  = gold_valid && gold_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = hit_q && (!full || do_pop);
  // Carry out of bit 31 marks the current launch as the last one of the job.
  assign next_sum = {1'b0, dp_nonce_q} + 33'(NONCE_STRIDE);

  always_comb begin
    state_d       = state_q;
    dp_midstate_d = dp_midstate_q;
    dp_data_d     = dp_data_q;
    target_d      = target_q;
    dp_nonce_d    = dp_nonce_q;
    dp_valid_d    = 1'b0;
    drain_cnt_d   = drain_cnt_q;
    work_done_d   = 1'b0;
    vld_pipe_d    = {vld_pipe_q[PIPE_LATENCY-2:0], dp_valid_q};
    // Launches are contiguous, so the returning nonce is just a running count.
    res_nonce_d   = v_out ? res_nonce_q + 32'(NONCE_STRIDE) : res_nonce_q;
    hit_d         = v_out && (hash_in[255:224] == 32'h0) &&
                    (hash_in[223:192] <= target_q);
    hit_nonce_d   = res_nonce_q;

    case (state_q)
      RUN: begin
        if (next_sum[32]) begin
          state_d     = DRAIN;
          drain_cnt_d = CW'(PIPE_LATENCY);
        end else begin
          dp_nonce_d = next_sum[31:0];
          dp_valid_d = 1'b1;
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q - CW'(1);
        // The last launch's hash is on hash_in as the counter hits zero.
        if (drain_cnt_q <= CW'(1)) begin
          drain_cnt_d = '0;
          work_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    // A new job preempts anything in flight, including a pending hit and a
    // drain that would otherwise signal completion of the old job.
    if (accept) begin
      state_d       = RUN;
      dp_midstate_d = work_midstate;
      dp_data_d     = work_data;
      target_d      = work_target;
      dp_nonce_d    = work_nonce_start;
      dp_valid_d    = 1'b1;
      res_nonce_d   = work_nonce_start;
      vld_pipe_d    = '0;
      hit_d         = 1'b0;
      drain_cnt_d   = '0;
      work_done_d   = 1'b0;
    end

    wr_ptr_d = do_push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + (FIFO_AW+1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (FIFO_AW+1)'(1);
    ovf_d = ovf_q;
    if (hit_q && !do_push && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dp_midstate_q <= '0;
      dp_data_q     <= '0;
      target_q      <= '0;
      dp_nonce_q    <= '0;
      dp_valid_q    <= 1'b0;
      vld_pipe_q    <= '0;
      res_nonce_q   <= '0;
      drain_cnt_q   <= '0;
      work_done_q   <= 1'b0;
      hit_q         <= 1'b0;
      hit_nonce_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      ovf_q         <= '0;
    end else begin
      state_q       <= state_d;
      dp_midstate_q <= dp_midstate_d;
      dp_data_q     <= dp_data_d;
      target_q      <= target_d;
      dp_nonce_q    <= dp_nonce_d;
      dp_valid_q    <= dp_valid_d;
      vld_pipe_q    <= vld_pipe_d;
      res_nonce_q   <= res_nonce_d;
      drain_cnt_q   <= drain_cnt_d;
      work_done_q   <= work_done_d;
      hit_q         <= hit_d;
      hit_nonce_q   <= hit_nonce_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= hit_nonce_q;
  end

  assign work_ready  = 1'b1;
  assign dp_midstate = dp_midstate_q;
  assign dp_data     = dp_data_q;
  assign dp_nonce    = dp_nonce_q;
  assign dp_valid    = dp_valid_q;
  assign gold_valid  = (cnt_q != '0);
  assign gold_nonce  = gold_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign ovf_count   = ovf_q;
  assign busy        = (state_q != IDLE);
  assign work_done   = work_done_q;

endmodule

// File: tb/tb_sha256d_nonce_scheduler.sv
// Testbench for sha256d_nonce_scheduler: PIPE_LATENCY=4, NONCE_STRIDE=1,
// FIFO_AW=1, with a 4-deep delay-line mock datapath whose hash is golden
// (H7=0, H6=g_h6) only for nonces in [g_lo,g_hi] or equal to g2.
module tb_sha256d_nonce_scheduler;
  localparam int PL = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         work_valid = 1'b0;
  logic         work_ready;
  logic [255:0] work_midstate = '0;
  logic [95:0]  work_data = '0;
  logic [31:0]  work_nonce_start = '0;
  logic [31:0]  work_target = '0;
  logic [255:0] dp_midstate;
  logic [95:0]  dp_data;
  logic [31:0]  dp_nonce;
  logic         dp_valid;
  logic [255:0] hash_in;
  logic         gold_valid;
  logic         gold_ready = 1'b1;
  logic [31:0]  gold_nonce;
  logic [7:0]   ovf_count;
  logic         busy;
  logic         work_done;

  always #5 clk = ~clk;

  sha256d_nonce_scheduler #(.PIPE_LATENCY(PL), .NONCE_STRIDE(1), .FIFO_AW(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .work_valid(work_valid), .work_ready(work_ready),
    .work_midstate(work_midstate), .work_data(work_data),
    .work_nonce_start(work_nonce_start), .work_target(work_target),
    .dp_midstate(dp_midstate), .dp_data(dp_data),
    .dp_nonce(dp_nonce), .dp_valid(dp_valid),
    .hash_in(hash_in),
    .gold_valid(gold_valid), .gold_ready(gold_ready), .gold_nonce(gold_nonce),
    .ovf_count(ovf_count), .busy(busy), .work_done(work_done)
  );

  // Mock datapath: nonce delay line, hash derived from the oldest entry.
  logic [31:0] dl [PL];
  logic [31:0] g_lo = 32'h1, g_hi = 32'h0, g2 = 32'hDEADBEEF, g_h6 = 32'h0;

  always @(posedge clk) begin
    dl[0] <= dp_nonce;
    for (int i = 1; i < PL; i++) dl[i] <= dl[i-1];
  end

  always_comb begin
    hash_in = {32'h1, 32'h0, 192'h0};
    if ((dl[PL-1] >= g_lo && dl[PL-1] <= g_hi) || dl[PL-1] == g2)
      hash_in = {32'h0, g_h6, 192'h0};
  end

  typedef struct {
    logic [31:0] start;
    logic [31:0] gn;
    logic [31:0] h6;
    logic [31:0] tgt;
    logic        exp;
  } vec_t;
  vec_t vt [6];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] s, input logic [31:0] t);
    work_nonce_start = s;
    work_target      = t;
    work_midstate    = {8{s}};
    work_data        = {3{~s}};
    work_valid       = 1'b1;
    step();
    work_valid       = 1'b0;
  endtask

  initial begin
    logic bad;
    int   k;

    vt[0] = '{32'h0000_0000, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[1] = '{32'h0000_1000, 32'h0000_1003, 32'h0000_FFFF, 32'h0000_FFFF, 1'b1};
    vt[2] = '{32'h0000_2000, 32'h0000_2003, 32'h0001_0000, 32'h0000_FFFF, 1'b0};
    vt[3] = '{32'h0000_3000, 32'h0000_3000, 32'h0000_0007, 32'h0000_0008, 1'b1};
    vt[4] = '{32'h0000_4000, 32'h0000_4001, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0};
    vt[5] = '{32'h0000_5000, 32'h0000_5002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dp_valid", 32'(dp_valid), 0);
    chk("rst_dp_nonce", dp_nonce, 0);
    chk("rst_gold_valid", 32'(gold_valid), 0);
    chk("rst_gold_nonce", gold_nonce, 0);
    chk("rst_ovf", 32'(ovf_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_work_done", 32'(work_done), 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("work_ready", 32'(work_ready), 1);

    // Table-driven: launch sequence, golden latency, target compare
    for (int i = 0; i < 6; i++) begin
      g_lo = vt[i].gn; g_hi = vt[i].gn; g_h6 = vt[i].h6;
      k = int'(vt[i].gn - vt[i].start);
      start_job(vt[i].start, vt[i].tgt);
      chk("launch0_nonce", dp_nonce, vt[i].start);
      chk("launch0_valid", 32'(dp_valid), 1);
      chk("midstate", 32'(dp_midstate == {8{vt[i].start}}), 1);
      chk("data", 32'(dp_data == {3{~vt[i].start}}), 1);
      bad = 1'b0;
      for (int j = 1; j <= k + 5; j++) begin
        step();
        if (gold_valid) bad = 1'b1;
        if (dp_nonce !== vt[i].start + 32'(j) || dp_valid !== 1'b1) bad = 1'b1;
      end
      chk("seq_before_gold", 32'(bad), 0);
      step();
      chk("gold_valid", 32'(gold_valid), 32'(vt[i].exp));
      if (vt[i].exp) chk("gold_nonce", gold_nonce, vt[i].gn);
      step();
      chk("gold_popped", 32'(gold_valid), 0);
    end

    // Wrap at end of nonce space, drain and work_done
    g_lo = 32'hFFFF_FFFE; g_hi = 32'hFFFF_FFFE; g_h6 = 32'h0;
    start_job(32'hFFFF_FFFC, 32'h0);
    chk("wrap_n0", dp_nonce, 32'hFFFF_FFFC);
    for (int j = 1; j <= 3; j++) begin
      step();
      chk("wrap_nonce", dp_nonce, 32'hFFFF_FFFC + 32'(j));
    end
    step();
    chk("wrap_valid_off", 32'(dp_valid), 0);
    chk("wrap_nonce_hold", dp_nonce, 32'hFFFF_FFFF);
    chk("wrap_busy_drain", 32'(busy), 1);
    bad = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      if (work_done || !busy) bad = 1'b1;
    end
    chk("drain_no_early_done", 32'(bad), 0);
    step();
    chk("work_done_pulse", 32'(work_done), 1);
    chk("busy_fall", 32'(busy), 0);
    chk("wrap_gold_valid", 32'(gold_valid), 1);
    chk("wrap_gold_nonce", gold_nonce, 32'hFFFF_FFFE);
    step();
    chk("work_done_1cyc", 32'(work_done), 0);
    chk("idle_dp_valid", 32'(dp_valid), 0);
    chk("wrap_popped", 32'(gold_valid), 0);

    // FIFO overflow with host stalled
    gold_ready = 1'b0;
    g_lo = 32'h20; g_hi = 32'h22; g_h6 = 32'h0;
    start_job(32'h1E, 32'h0);
    for (int j = 0; j < 10; j++) step();
    chk("ovf_head", gold_nonce, 32'h20);
    chk("ovf_valid", 32'(gold_valid), 1);
    chk("ovf_count", 32'(ovf_count), 1);
    gold_ready = 1'b1;
    step();
    chk("ovf_pop1", gold_nonce, 32'h21);
    chk("ovf_pop1_valid", 32'(gold_valid), 1);
    step();
    chk("ovf_empty", 32'(gold_valid), 0);
    chk("ovf_hold", 32'(ovf_count), 1);
    g_lo = 32'h1; g_hi = 32'h0;

    // New job two cycles after a golden launch discards it
    g_lo = 32'h10; g_hi = 32'h10; g2 = 32'h102;
    start_job(32'h0E, 32'h0);
    step(); step(); step();
    start_job(32'h100, 32'h0);
    chk("newjob_nonce", dp_nonce, 32'h100);
    chk("newjob_valid", 32'(dp_valid), 1);
    bad = 1'b0;
    for (int j = 0; j < 7; j++) begin
      step();
      if (gold_valid) bad = 1'b1;
    end
    chk("old_gold_discarded", 32'(bad), 0);
    step();
    chk("newjob_gold_valid", 32'(gold_valid), 1);
    chk("newjob_res_nonce", gold_nonce, 32'h102);
    step();
    g_lo = 32'h1; g_hi = 32'h0; g2 = 32'hDEADBEEF;

    // Reset mid-run with a golden waiting in the FIFO
    gold_ready = 1'b0;
    g_lo = 32'h2; g_hi = 32'h2;
    start_job(32'h0, 32'h0);
    for (int j = 0; j < 8; j++) step();
    chk("pre_rst_gold", 32'(gold_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_dp_valid", 32'(dp_valid), 0);
    chk("mrst_gold_valid", 32'(gold_valid), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_ovf", 32'(ovf_count), 0);
    chk("mrst_work_done", 32'(work_done), 0);
    step(); step();
    rst_n = 1'b1;
    gold_ready = 1'b1;
    bad = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step();
      if (work_done || gold_valid || dp_valid || busy) bad = 1'b1;
    end
    chk("post_rst_quiet", 32'(bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
